// File: rtl/learning_mode_controller.sv
// learning_mode_controller: fetches song notes, guides the player via LEDs, scores key presses
// Ports: i_clk/i_reset (sync, active-high), i_enable selects learning mode,
//        i_key_in raw keys, i_note_valid/i_note_code/o_note_req upstream note handshake,
//        o_led_guide expected key, o_note_out tone code, o_score hit count,
//        o_hit/o_miss one-cycle pulses, o_song_done end-of-song flag.
module learning_mode_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TIMEOUT_CYCLES  = 300_000_000,
    parameter int TONE_CYCLES     = 30_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [6:0] i_key_in,
    input  logic       i_note_valid,
    input  logic [3:0] i_note_code,
    output logic       o_note_req,
    output logic [6:0] o_led_guide,
    output logic [3:0] o_note_out,
    output logic [7:0] o_score,
    output logic       o_hit,
    output logic       o_miss,
    output logic       o_song_done
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam int TOW = $clog2(TIMEOUT_CYCLES);
    localparam int TNW = $clog2(TONE_CYCLES);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT_KEY, S_PLAY, S_RELEASE, S_DONE} state_t;
    state_t r_state, w_state_n;
    logic [6:0] r_sync1, r_sync2, r_sync3, r_kv, r_kv_prev;
    logic [DBW-1:0] r_db_cnt;
    logic [TOW-1:0] r_tmo, w_tmo_n;
    logic [TNW-1:0] r_tone, w_tone_n;
    logic [3:0] r_code, w_code_n;
    logic [7:0] w_score_n;
    logic w_hit_n, w_miss_n, w_press, w_stable, w_rest;
    logic [6:0] w_onehot;
    assign w_stable = r_sync2 == r_sync3;
    assign w_press  = (r_kv != 7'd0) && (r_kv_prev == 7'd0);
    assign w_onehot = 7'd1 << (r_code[2:0] - 3'd1);
    assign w_rest   = (i_note_code == 4'd0) || (i_note_code[3] && i_note_code != 4'd15);
    // r_sync3 holds the previous synchronized sample so the debouncer can see a change
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sync3   <= '0;
            r_kv      <= '0;
            r_kv_prev <= '0;
            r_db_cnt  <= '0;
        end else begin
            r_sync1   <= i_key_in;
            r_sync2   <= r_sync1;
            r_sync3   <= r_sync2;
            r_kv_prev <= r_kv;
            if (r_sync2 == r_kv || !w_stable)
                r_db_cnt <= '0;
            else if (r_db_cnt == DBW'(DEBOUNCE_CYCLES - 2)) begin
                r_kv     <= r_sync2;
                r_db_cnt <= '0;
            end else
                r_db_cnt <= r_db_cnt + DBW'(1);
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_code  <= '0;
            r_tmo   <= '0;
            r_tone  <= '0;
            o_score <= '0;
            o_hit   <= 1'b0;
            o_miss  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_code  <= w_code_n;
            r_tmo   <= w_tmo_n;
            r_tone  <= w_tone_n;
            o_score <= w_score_n;
            o_hit   <= w_hit_n;
            o_miss  <= w_miss_n;
        end
    end
    always_comb begin
        w_state_n = r_state;
        w_code_n  = r_code;
        w_tmo_n   = r_tmo;
        w_tone_n  = r_tone;
        w_score_n = o_score;
        w_hit_n   = 1'b0;
        w_miss_n  = 1'b0;
        if (!i_enable)
            w_state_n = S_IDLE;
        else
            case (r_state)
                S_IDLE: begin
                    w_score_n = '0;
                    w_state_n = S_FETCH;
                end
                S_FETCH:
                    if (i_note_valid && !w_rest) begin
                        w_code_n  = i_note_code;
                        w_tmo_n   = '0;
                        w_state_n = i_note_code == 4'd15 ? S_DONE : S_WAIT_KEY;
                    end
                S_WAIT_KEY: begin
                    w_tmo_n = r_tmo + TOW'(1);
                    // a press in the timeout cycle takes priority over the timeout
                    if (w_press && r_kv == w_onehot) begin
                        w_hit_n   = 1'b1;
                        w_score_n = o_score + {7'd0, o_score != 8'hFF};
                        w_tone_n  = '0;
                        w_state_n = S_PLAY;
                    end else if (w_press)
                        w_miss_n = 1'b1;
                    else if (r_tmo == TOW'(TIMEOUT_CYCLES - 1)) begin
                        w_miss_n  = 1'b1;
                        w_state_n = S_FETCH;
                    end
                end
                S_PLAY: begin
                    w_tone_n  = r_tone + TNW'(1);
                    w_state_n = r_tone == TNW'(TONE_CYCLES - 1) ? S_RELEASE : S_PLAY;
                end
                S_RELEASE: w_state_n = r_kv == 7'd0 ? S_FETCH : S_RELEASE;
                default: w_state_n = r_state;
            endcase
    end
    always_comb begin
        o_note_req  = r_state == S_FETCH;
        o_song_done = r_state == S_DONE;
        o_note_out  = r_state == S_PLAY ? r_code : 4'd0;
        o_led_guide = r_state == S_WAIT_KEY ? w_onehot : r_state == S_DONE ? 7'h7F : 7'd0;
    end
endmodule

// File: tb/tb_learning_mode_controller.sv
// tb_learning_mode_controller: directed self-checking bench for learning_mode_controller
module tb_learning_mode_controller;
    logic clk = 1'b0;
    logic reset, enable, note_valid;
    logic [6:0] key_in;
    logic [3:0] note_code;
    logic note_req, hit, miss, song_done;
    logic [6:0] led_guide;
    logic [3:0] note_out;
    logic [7:0] score;
    int n_checks = 0;
    int n_fail = 0;
    learning_mode_controller #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100), .TONE_CYCLES(20)) dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_key_in(key_in),
        .i_note_valid(note_valid), .i_note_code(note_code), .o_note_req(note_req),
        .o_led_guide(led_guide), .o_note_out(note_out), .o_score(score),
        .o_hit(hit), .o_miss(miss), .o_song_done(song_done)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic sig(input int sel);
        return sel == 0 ? hit : sel == 1 ? miss : note_req;
    endfunction
    task automatic wait_for(input string tag, input int sel, input int lim, output int n);
        n = 0;
        while (!sig(sel) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sig(sel)), 32'd1);
    endtask
    task automatic offer(input logic [3:0] c);
        int n;
        wait_for("offer_req", 2, 100, n);
        note_valid = 1'b1;
        note_code  = c;
        @(negedge clk);
        note_valid = 1'b0;
        note_code  = 4'd0;
    endtask
    task automatic play_note(input logic [3:0] c);
        int n;
        logic [6:0] oh;
        oh = 7'd1 << (c - 4'd1);
        offer(c);
        check("note_led", 32'(led_guide), 32'(oh));
        key_in = oh;
        wait_for("note_hit", 0, 40, n);
        key_in = 7'd0;
        wait_for("note_next_req", 2, 80, n);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int n, pulses;
        logic led_ok;
        reset = 1'b1;
        enable = 1'b0;
        key_in = 7'd0;
        note_valid = 1'b0;
        note_code = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_score", 32'(score), 32'd0);
        check("rst_req", 32'(note_req), 32'd0);
        check("rst_led", 32'(led_guide), 32'd0);
        check("rst_note", 32'(note_out), 32'd0);
        check("rst_pulses", 32'({hit, miss, song_done}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_req", 32'(note_req), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check("fetch_req", 32'(note_req), 32'd1);
        check("fetch_led", 32'(led_guide), 32'd0);
        // correct press of code 3
        offer(4'd3);
        check("c3_led", 32'(led_guide), 32'h04);
        check("c3_req_drop", 32'(note_req), 32'd0);
        key_in = 7'b0000100;
        n = 0;
        led_ok = 1'b1;
        while (!hit && n < 40) begin
            if (led_guide != 7'b0000100) led_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check("c3_led_hold", 32'(led_ok), 32'd1);
        check("c3_hit", 32'(hit), 32'd1);
        check("c3_score", 32'(score), 32'd1);
        check("c3_led_clr", 32'(led_guide), 32'd0);
        check("c3_no_miss", 32'(miss), 32'd0);
        @(negedge clk);
        check("c3_hit_1cyc", 32'(hit), 32'd0);
        n = 1;
        while (note_out == 4'd3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("c3_tone_len", 32'(n), 32'd20);
        check("c3_tone_off", 32'(note_out), 32'd0);
        repeat (5) @(negedge clk);
        check("c3_release_hold", 32'(note_req), 32'd0);
        key_in = 7'd0;
        wait_for("c3_req_again", 2, 30, n);
        // wrong key then correct key for code 5
        offer(4'd5);
        key_in = 7'b0000001;
        wait_for("c5_miss", 1, 30, n);
        check("c5_led_stay", 32'(led_guide), 32'h10);
        check("c5_no_hit", 32'(hit), 32'd0);
        @(negedge clk);
        check("c5_miss_1cyc", 32'(miss), 32'd0);
        key_in = 7'd0;
        repeat (10) @(negedge clk);
        key_in = 7'b0010000;
        wait_for("c5_hit", 0, 30, n);
        check("c5_score", 32'(score), 32'd2);
        key_in = 7'd0;
        wait_for("c5_req_again", 2, 80, n);
        // timeout on code 2
        offer(4'd2);
        n = 0;
        while (!miss && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("to_delay", 32'(n), 32'd100);
        check("to_req", 32'(note_req), 32'd1);
        check("to_score", 32'(score), 32'd2);
        check("to_led", 32'(led_guide), 32'd0);
        // reset in WAIT_KEY with score 3
        play_note(4'd1);
        check("pre_rst_score", 32'(score), 32'd3);
        offer(4'd6);
        check("pre_rst_led", 32'(led_guide), 32'h20);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_score", 32'(score), 32'd0);
        check("mid_rst_led", 32'(led_guide), 32'd0);
        check("mid_rst_req", 32'(note_req), 32'd0);
        check("mid_rst_pulse", 32'({hit, miss}), 32'd0);
        @(negedge clk);
        check("post_rst_req", 32'(note_req), 32'd1);
        // stream 0, 9, 4, 15
        offer(4'd0);
        check("rest0_req", 32'(note_req), 32'd1);
        check("rest0_led", 32'(led_guide), 32'd0);
        offer(4'd9);
        check("rest9_req", 32'(note_req), 32'd1);
        check("rest9_score", 32'(score), 32'd0);
        play_note(4'd4);
        offer(4'd15);
        check("done_flag", 32'(song_done), 32'd1);
        check("done_led", 32'(led_guide), 32'h7F);
        check("done_req", 32'(note_req), 32'd0);
        check("done_score", 32'(score), 32'd1);
        repeat (3) @(negedge clk);
        check("done_hold", 32'(song_done), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("dis_done", 32'(song_done), 32'd0);
        check("dis_led", 32'(led_guide), 32'd0);
        check("dis_score", 32'(score), 32'd1);
        enable = 1'b1;
        @(negedge clk);
        check("reen_score", 32'(score), 32'd0);
        check("reen_req", 32'(note_req), 32'd1);
        // 3-cycle glitch must not create a press
        offer(4'd7);
        key_in = 7'b1000000;
        repeat (3) @(negedge clk);
        key_in = 7'd0;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (hit || miss) pulses++;
        end
        check("glitch_pulses", 32'(pulses), 32'd0);
        check("glitch_led", 32'(led_guide), 32'h40);
        key_in = 7'b1000000;
        wait_for("glitch_hit", 0, 30, n);
        check("glitch_score", 32'(score), 32'd1);
        key_in = 7'd0;
        wait_for("glitch_req", 2, 80, n);
        // saturation
        for (int i = 0; i < 254; i++) play_note(4'(i % 7 + 1));
        check("sat_255", 32'(score), 32'd255);
        play_note(4'd2);
        check("sat_hold", 32'(score), 32'd255);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
